// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
// The requester drives start and operands; the subtractor returns status and result.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;

  modport master (
    output start, a, b, bin,
    input  ready, done, diff, bout
  );

  modport slave (
    input  start, a, b, bin,
    output ready, done, diff, bout
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first.
// State | meaning: IDLE = ready, waiting for start; RUN = one bit per edge; DONE = result valid for one cycle.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input logic               clk,
  input logic               rst,
  serial_subtractor_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_diff;
  logic             r_w;
  logic             r_bout;
  logic             r_ready;
  logic             r_done;
  logic [CW-1:0]    r_cnt;

  logic             w_ai;
  logic             w_bi;
  logic             w_d;
  logic             w_w_next;
  logic [WIDTH-1:0] w_acc_next;

  always_comb begin
    w_ai       = r_a[r_cnt];
    w_bi       = r_b[r_cnt];
    w_d        = w_ai ^ w_bi ^ r_w;
    w_w_next   = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & r_w);
    w_acc_next = r_acc;
    w_acc_next[r_cnt] = w_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_diff  <= '0;
      r_w     <= 1'b0;
      r_bout  <= 1'b0;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_w     <= bus.bin;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_ready <= 1'b0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_acc <= w_acc_next;
          r_w   <= w_w_next;
          // Result registers change only here so no partial value is ever visible.
          if (r_cnt == CW'(WIDTH - 1)) begin
            r_diff  <= w_acc_next;
            r_bout  <= w_w_next;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.ready = r_ready;
  assign bus.done  = r_done;
  assign bus.diff  = r_diff;
  assign bus.bout  = r_bout;
endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench: 8-bit directed vectors with a cycle-level reference model, plus exhaustive 4-bit sweep.
module tb_serial_subtractor;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(8)) if8 ();
  serial_subtractor_if #(.WIDTH(4)) if4 ();

  serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));
  serial_subtractor #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));

  int tests = 0;
  int fails = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model for the 8-bit instance: an operation launched at edge e
  // finishes at edge e+8 and the unit accepts again from edge e+10.
  int         e;
  int         m_launch;
  int         m_free;
  logic [7:0] m_pend_d, m_exp_d;
  logic       m_pend_b, m_exp_b, m_exp_done, m_exp_ready;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      e = 0; m_launch = -100; m_free = 0;
      m_exp_d = 0; m_exp_b = 0; m_exp_done = 0; m_exp_ready = 1;
    end else begin
      e++;
      if (if8.start && e >= m_free) begin
        m_launch = e;
        m_free   = e + 10;
        m_pend_d = 8'(int'(if8.a) - int'(if8.b) - int'(if8.bin));
        m_pend_b = (int'(if8.a) < int'(if8.b) + int'(if8.bin));
      end
      m_exp_done = (e == m_launch + 8);
      if (m_exp_done) begin
        m_exp_d = m_pend_d;
        m_exp_b = m_pend_b;
      end
      m_exp_ready = (e + 1 >= m_free);
    end
  end

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      chk("cyc_ready", int'(if8.ready), int'(m_exp_ready));
      chk("cyc_done",  int'(if8.done),  int'(m_exp_done));
      chk("cyc_diff",  int'(if8.diff),  int'(m_exp_d));
      chk("cyc_bout",  int'(if8.bout),  int'(m_exp_b));
    end
  end

  // Called at a negedge; start is sampled on the following rising edge.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                     input int ed, input int eb, input string nm);
    int k;
    bit seen;
    if8.a = a; if8.b = b; if8.bin = bin; if8.start = 1'b1;
    @(negedge clk);
    if8.start = 1'b0;
    if8.a = ~a; if8.b = ~b; if8.bin = ~bin;
    k = 0; seen = 0;
    while (k < 20 && !seen) begin
      @(negedge clk);
      k++;
      seen = if8.done;
    end
    chk({nm, "_done_seen"}, int'(seen), 1);
    chk({nm, "_latency"}, k, 8);
    chk({nm, "_diff"}, int'(if8.diff), ed);
    chk({nm, "_bout"}, int'(if8.bout), eb);
    @(negedge clk);
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic bin);
    int k;
    bit seen;
    int ed, eb;
    ed = (int'(a) - int'(b) - int'(bin)) & 15;
    eb = (int'(a) < int'(b) + int'(bin)) ? 1 : 0;
    if4.a = a; if4.b = b; if4.bin = bin; if4.start = 1'b1;
    @(negedge clk);
    if4.start = 1'b0;
    k = 0; seen = 0;
    while (k < 12 && !seen) begin
      @(negedge clk);
      k++;
      seen = if4.done;
    end
    tests++;
    if (!seen || k != 4 || int'(if4.diff) != ed || int'(if4.bout) != eb) begin
      fails++;
      $display("FAIL sweep4 a=%0d b=%0d bin=%0d: got diff=%0d bout=%0d lat=%0d expected diff=%0d bout=%0d lat=4",
               a, b, bin, if4.diff, if4.bout, k, ed, eb);
    end
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nd;
    int dd, db;
    if8.start = 0; if8.a = 0; if8.b = 0; if8.bin = 0;
    if4.start = 0; if4.a = 0; if4.b = 0; if4.bin = 0;
    #1 rst = 1'b1;
    #1;
    chk("rst_ready", int'(if8.ready), 1);
    chk("rst_done",  int'(if8.done),  0);
    chk("rst_diff",  int'(if8.diff),  0);
    chk("rst_bout",  int'(if8.bout),  0);
    chk("rst4_ready", int'(if4.ready), 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;

    op8(8'd5,   8'd3,   1'b0, 2,   0, "v5m3");
    op8(8'd3,   8'd5,   1'b0, 254, 1, "v3m5");
    op8(8'd0,   8'd0,   1'b1, 255, 1, "v0m0b");
    op8(8'd255, 8'd255, 1'b0, 0,   0, "v255m255");
    op8(8'd200, 8'd55,  1'b1, 144, 0, "v200m55b");

    // Second start during RUN with different operands must be ignored.
    if8.a = 8'd5; if8.b = 8'd3; if8.bin = 1'b0; if8.start = 1'b1;
    @(negedge clk);
    if8.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    if8.a = 8'd100; if8.b = 8'd1; if8.bin = 1'b1; if8.start = 1'b1;
    @(negedge clk);
    if8.start = 1'b0;
    nd = 0; dd = -1; db = -1;
    repeat (12) begin
      @(negedge clk);
      if (if8.done) begin
        nd++;
        dd = int'(if8.diff);
        db = int'(if8.bout);
      end
    end
    chk("ign_done_count", nd, 1);
    chk("ign_diff", dd, 2);
    chk("ign_bout", db, 0);

    // Reset mid-RUN aborts the operation and clears outputs immediately.
    op8(8'd3, 8'd5, 1'b0, 254, 1, "pre_rst");
    if8.a = 8'd9; if8.b = 8'd4; if8.bin = 1'b0; if8.start = 1'b1;
    @(negedge clk);
    if8.start = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_ready", int'(if8.ready), 1);
    chk("abort_diff",  int'(if8.diff),  0);
    chk("abort_bout",  int'(if8.bout),  0);
    chk("abort_done",  int'(if8.done),  0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    op8(8'd7, 8'd9, 1'b0, 254, 1, "post_rst");

    // Held start relaunches every WIDTH+2 cycles; the cycle model checks timing.
    if8.a = 8'd20; if8.b = 8'd7; if8.bin = 1'b1; if8.start = 1'b1;
    nd = 0;
    repeat (30) begin
      @(negedge clk);
      if (if8.done) nd++;
    end
    if8.start = 1'b0;
    chk("held_start_dones", nd, 3);
    chk("held_start_diff", int'(if8.diff), 12);
    repeat (12) @(negedge clk);

    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 2; c++)
          op4(4'(a), 4'(b), 1'(c));

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
